// File: rtl/adc_emulator_if.sv
// adc_emulator_if: pin bundle between an ADC bank controller (master) and the
// ADCs, or the emulator that stands in for them (slave).
interface adc_emulator_if #(
    parameter int ADC_CHANNELS = 8
);
    logic                    adc_mclk;
    logic                    adc_scka;
    logic                    adc_sync;
    logic                    adc_sdi;
    logic [ADC_CHANNELS-1:0] adc_sdoa;

    modport master (
        output adc_mclk,
        output adc_scka,
        output adc_sync,
        output adc_sdi,
        input  adc_sdoa
    );

    modport slave (
        input  adc_mclk,
        input  adc_scka,
        input  adc_sync,
        input  adc_sdi,
        output adc_sdoa
    );
endinterface

// File: rtl/adc_emulator.sv
// adc_emulator: synthesizable stand-in for a bank of SPI-style decimating ADCs.
// Listens to mclk/scka/sync/sdi and returns per-channel words MSB first on
// adc_sdoa, either a recognisable internal pattern or externally supplied data.
// Also captures the first configuration word shifted in on sdi, counts mclk
// pulses per frame and flags protocol errors (sync/scka collision, overrun).
//
// Optional build macro ADC_EMULATOR_SYNC_EN: pass every pin through a two-flop
// synchronizer before edge detection (response latency 3 cycles instead of 1).
module adc_emulator #(
    parameter int ADC_CHANNELS = 8,
    parameter int ADC_BITS     = 24,
    parameter int CFG_BITS     = 8
) (
    input  logic                             capture_clk,
    input  logic                             capture_rst_n,
    adc_emulator_if.slave                    adc,
    input  logic                             use_ext,
    input  logic [ADC_CHANNELS*ADC_BITS-1:0] ext_data,
    output logic [CFG_BITS-1:0]              cfg_word,
    output logic                             cfg_valid,
    output logic [15:0]                      mclk_count,
    output logic                             err_collide,
    output logic                             err_overrun
);

    // Frame bit counter must hold ADC_BITS+1 (its saturation value).
    localparam int FBW = $clog2(ADC_BITS + 2);
    // Config bit counter saturates at CFG_BITS ("at least a full word seen").
    localparam int CBW = $clog2(CFG_BITS + 1);

    typedef struct packed {
        logic mclk;
        logic scka;
        logic sync;
        logic sdi;
    } pins_t;

    // Power-up pattern: nibble-tagged so a scope or dump shows channel and
    // frame number at a glance. Longer words are zero-extended at the top.
    function automatic logic [ADC_BITS-1:0] pattern_word(input int unsigned ch,
                                                         input logic [3:0]  w);
        logic [31:0] full;
        full = {4'(ch), 4'hA, w, 4'hB, 4'(ch), 4'hC, w, 4'hD};
        return ADC_BITS'(full);
    endfunction

    pins_t pins_raw;
    pins_t pins_in;
    pins_t pins_q;

    assign pins_raw = '{mclk: adc.adc_mclk, scka: adc.adc_scka,
                        sync: adc.adc_sync, sdi:  adc.adc_sdi};

`ifdef ADC_EMULATOR_SYNC_EN
    pins_t pins_s1;
    pins_t pins_s2;

    // Two-flop synchronizer for an externally clocked controller.
    always_ff @(posedge capture_clk) begin
        // NOTE: state is written with non-blocking assignments so every flop
        // samples the pre-edge value; blocking here would collapse the chain.
        if (!capture_rst_n) begin
            pins_s1 <= '0;
            pins_s2 <= '0;
        end else begin
            pins_s1 <= pins_raw;
            pins_s2 <= pins_s1;
        end
    end

    assign pins_in = pins_s2;
`else
    assign pins_in = pins_raw;
`endif

    // Previous-cycle copy of each pin for rising-edge detection.
    always_ff @(posedge capture_clk) begin
        if (!capture_rst_n) begin
            pins_q <= '0;
        end else begin
            pins_q <= pins_in;
        end
    end

    logic rise_mclk;
    logic rise_scka;
    logic rise_sync;
    logic do_shift;

    assign rise_mclk = pins_in.mclk & ~pins_q.mclk;
    assign rise_scka = pins_in.scka & ~pins_q.scka;
    assign rise_sync = pins_in.sync & ~pins_q.sync;
    // A load on the same edge wins; the colliding shift is dropped.
    assign do_shift  = rise_scka & ~rise_sync;

    // ------------------------------------------------------------------
    // Channel data path
    // ------------------------------------------------------------------
    logic [3:0]          wcnt;
    logic [ADC_BITS-1:0] load_word [ADC_CHANNELS];
    logic [ADC_BITS-1:0] shreg     [ADC_CHANNELS];

    // Word each channel would load if sync rose this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally per element) so no latch is inferred.
        for (int c = 0; c < ADC_CHANNELS; c++) begin
            load_word[c] = use_ext ? ext_data[c*ADC_BITS +: ADC_BITS]
                                   : pattern_word(c, wcnt);
        end
    end

    // Per-channel output shift registers: load on sync, shift left on scka.
    always_ff @(posedge capture_clk) begin
        // NOTE: this register array is reset explicitly: adc_sdoa must read 0
        // straight out of reset, so it cannot be left as uninitialised storage.
        if (!capture_rst_n) begin
            for (int c = 0; c < ADC_CHANNELS; c++) begin
                shreg[c] <= '0;
            end
        end else if (rise_sync) begin
            for (int c = 0; c < ADC_CHANNELS; c++) begin
                shreg[c] <= load_word[c];
            end
        end else if (do_shift) begin
            for (int c = 0; c < ADC_CHANNELS; c++) begin
                shreg[c] <= {shreg[c][ADC_BITS-2:0], 1'b0};
            end
        end
    end

    // The pin is the register MSB directly: no logic between flop and pad.
    for (genvar c = 0; c < ADC_CHANNELS; c++) begin : g_sdoa
        assign adc.adc_sdoa[c] = shreg[c][ADC_BITS-1];
    end

    // Pattern frame number, advanced on every load and wrapping 15 -> 0.
    always_ff @(posedge capture_clk) begin
        if (!capture_rst_n) begin
            wcnt <= 4'd1;
        end else if (rise_sync) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame bookkeeping and sticky errors
    // ------------------------------------------------------------------
    logic [FBW-1:0] fcnt;

    // Bits shifted since the last sync; saturates one past a full word.
    always_ff @(posedge capture_clk) begin
        if (!capture_rst_n) begin
            fcnt        <= '0;
            err_overrun <= 1'b0;
        end else if (rise_sync) begin
            fcnt <= '0;
        end else if (do_shift) begin
            if (fcnt == FBW'(ADC_BITS)) begin
                err_overrun <= 1'b1;
            end
            if (fcnt != FBW'(ADC_BITS + 1)) begin
                fcnt <= fcnt + FBW'(1);
            end
        end
    end

    // Sticky flag for a sync and scka rising on the same capture edge.
    always_ff @(posedge capture_clk) begin
        if (!capture_rst_n) begin
            err_collide <= 1'b0;
        end else if (rise_sync && rise_scka) begin
            err_collide <= 1'b1;
        end
    end

    // mclk pulses since the last sync; a coincident sync restarts at 1.
    always_ff @(posedge capture_clk) begin
        if (!capture_rst_n) begin
            mclk_count <= 16'd0;
        end else if (rise_mclk) begin
            if (rise_sync) begin
                mclk_count <= 16'd1;
            end else if (mclk_count != 16'hFFFF) begin
                mclk_count <= mclk_count + 16'd1;
            end
        end else if (rise_sync) begin
            mclk_count <= 16'd0;
        end
    end

    // ------------------------------------------------------------------
    // One-shot configuration capture
    // ------------------------------------------------------------------
    logic [CFG_BITS-1:0] cfg_shift;
    logic [CBW-1:0]      cfg_cnt;
    logic                cfg_done;

    // Collect sdi on scka until the first mclk, then latch (or give up) once.
    always_ff @(posedge capture_clk) begin
        if (!capture_rst_n) begin
            cfg_shift <= '0;
            cfg_cnt   <= '0;
            cfg_done  <= 1'b0;
            cfg_word  <= '0;
            cfg_valid <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            if (!cfg_done) begin
                if (rise_mclk) begin
                    cfg_done <= 1'b1;
                    if (cfg_cnt == CBW'(CFG_BITS)) begin
                        cfg_word  <= cfg_shift;
                        cfg_valid <= 1'b1;
                    end
                end else if (rise_scka) begin
                    cfg_shift <= {cfg_shift[CFG_BITS-2:0], pins_in.sdi};
                    if (cfg_cnt != CBW'(CFG_BITS)) begin
                        cfg_cnt <= cfg_cnt + CBW'(1);
                    end
                end
            end
        end
    end

endmodule
